// File: rtl/stream_rr_arbiter.sv
// Packet-locked round-robin arbiter and N:1 stream mux. Holds the grant until the
// granted source's last beat handshakes, then rotates priority to the next source.
module stream_rr_arbiter #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 5,
  parameter int M_DATA_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [S_DATA_COUNT*T_DATA_WIDTH-1:0] s_data_i,
  input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]              s_valid_i,
  input  logic [S_DATA_COUNT-1:0]              s_last_i,
  output logic [S_DATA_COUNT-1:0]              s_ready_o,
  output logic [T_DATA_WIDTH-1:0]              m_data_o,
  output logic [T_DEST_WIDTH-1:0]              m_dest_o,
  output logic [T_ID___WIDTH-1:0]              m_id_o,
  output logic                                 m_valid_o,
  output logic                                 m_last_o,
  input  logic                                 m_ready_i,
  output logic                                 busy_o
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [T_ID___WIDTH-1:0] LAST_IDX = T_ID___WIDTH'(S_DATA_COUNT - 1);

  state_t                  state_q, state_d;
  logic [T_ID___WIDTH-1:0] grant_q, grant_d;
  logic [T_ID___WIDTH-1:0] ptr_q, ptr_d;
  logic [T_ID___WIDTH-1:0] ptr_next;
  logic [S_DATA_COUNT-1:0] req_masked;
  logic                    locked;
  logic                    hs_last;

  // First requester scanning upward from start, wrapping by compare rather than modulo.
  function automatic logic [T_ID___WIDTH-1:0] rr_pick(
    input logic [S_DATA_COUNT-1:0] req,
    input logic [T_ID___WIDTH-1:0] start
  );
    logic [T_ID___WIDTH-1:0] idx;
    logic [T_ID___WIDTH-1:0] win;
    logic                    found;
    idx   = start;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
      idx = (idx == LAST_IDX) ? '0 : idx + T_ID___WIDTH'(1);
    end
    return win;
  endfunction

  assign locked = (state_q == LOCKED);
  assign busy_o = locked;

  always_comb begin
    s_ready_o = '0;
    m_valid_o = 1'b0;
    m_last_o  = 1'b0;
    m_data_o  = '0;
    m_dest_o  = '0;
    m_id_o    = '0;
    if (locked) begin
      s_ready_o[grant_q] = m_ready_i;
      m_valid_o          = s_valid_i[grant_q];
      m_last_o           = s_last_i[grant_q] & s_valid_i[grant_q];
      m_data_o           = s_data_i[int'(grant_q)*T_DATA_WIDTH +: T_DATA_WIDTH];
      m_dest_o           = s_dest_i[int'(grant_q)*T_DEST_WIDTH +: T_DEST_WIDTH];
      m_id_o             = grant_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    ptr_next   = (grant_q == LAST_IDX) ? '0 : grant_q + T_ID___WIDTH'(1);
    req_masked = s_valid_i & ~(S_DATA_COUNT'(1) << grant_q);
    hs_last    = locked & m_valid_o & m_ready_i & m_last_o;
    case (state_q)
      IDLE: begin
        if (|s_valid_i) begin
          grant_d = rr_pick(s_valid_i, ptr_q);
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        // Same-cycle hand-over; the finishing source is excluded so others get a turn.
        if (hs_last) begin
          ptr_d = ptr_next;
          if (|req_masked) grant_d = rr_pick(req_masked, ptr_next);
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed scenarios plus randomized traffic checked by a
// round-robin reference model and per-source beat scoreboard.
module tb_stream_rr_arbiter;
  localparam int W  = 8;
  localparam int S  = 5;
  localparam int M  = 3;
  localparam int IW = 3;
  localparam int DW = 2;

  typedef logic [DW+W:0] beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [S*W-1:0]  s_data_i;
  logic [S*DW-1:0] s_dest_i;
  logic [S-1:0]    s_valid_i;
  logic [S-1:0]    s_last_i;
  logic [S-1:0]    s_ready_o;
  logic [W-1:0]    m_data_o;
  logic [DW-1:0]   m_dest_o;
  logic [IW-1:0]   m_id_o;
  logic            m_valid_o;
  logic            m_last_o;
  logic            m_ready_i;
  logic            busy_o;

  stream_rr_arbiter #(
    .T_DATA_WIDTH(W), .S_DATA_COUNT(S), .M_DATA_COUNT(M),
    .T_ID___WIDTH(IW), .T_DEST_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data_i), .s_dest_i(s_dest_i), .s_valid_i(s_valid_i),
    .s_last_i(s_last_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_dest_o(m_dest_o), .m_id_o(m_id_o),
    .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t src_q[S][$];
  beat_t exp_q[S][$];
  bit    sb_en = 1'b0;

  // Reference model: lock flag, granted source, priority pointer.
  bit    mdl_locked = 1'b0;
  int    mdl_grant  = 0;
  int    mdl_ptr    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [S-1:0] req, input int start);
    for (int i = 0; i < S; i++)
      if (req[(start + i) % S]) return (start + i) % S;
    return -1;
  endfunction

  always @(negedge clk) begin : monitor
    logic [S-1:0] exp_rdy;
    logic [S-1:0] masked;
    beat_t        e;
    if (!rst_n) begin
      chk("reset_outputs",
          {s_ready_o, m_valid_o, m_last_o, busy_o, m_id_o, m_data_o, m_dest_o}, '0);
      mdl_locked = 1'b0;
      mdl_grant  = 0;
      mdl_ptr    = 0;
    end else begin
      exp_rdy = '0;
      if (mdl_locked) exp_rdy[mdl_grant] = m_ready_i;
      chk("busy", busy_o, mdl_locked);
      chk("s_ready", s_ready_o, exp_rdy);
      chk("m_valid", m_valid_o, mdl_locked && s_valid_i[mdl_grant]);
      chk("m_last", m_last_o, mdl_locked && s_valid_i[mdl_grant] && s_last_i[mdl_grant]);
      chk("m_id", m_id_o, mdl_locked ? mdl_grant : 0);
      chk("m_data", m_data_o, mdl_locked ? s_data_i[mdl_grant*W +: W] : 0);
      chk("m_dest", m_dest_o, mdl_locked ? s_dest_i[mdl_grant*DW +: DW] : 0);
      if (sb_en && m_valid_o && m_ready_i && int'(m_id_o) < S) begin
        chk("sb_beat_expected", exp_q[m_id_o].size() != 0, 1);
        if (exp_q[m_id_o].size() != 0) begin
          e = exp_q[m_id_o].pop_front();
          chk("sb_beat", {m_last_o, m_dest_o, m_data_o}, e);
        end
      end
      // Advance the model to the state after the coming rising edge.
      if (!mdl_locked) begin
        if (s_valid_i != 0) begin
          mdl_grant  = rr_pick(s_valid_i, mdl_ptr);
          mdl_locked = 1'b1;
        end
      end else if (s_valid_i[mdl_grant] && s_last_i[mdl_grant] && m_ready_i) begin
        mdl_ptr = (mdl_grant + 1) % S;
        masked  = s_valid_i;
        masked[mdl_grant] = 1'b0;
        if (masked != 0) mdl_grant = rr_pick(masked, mdl_ptr);
        else             mdl_locked = 1'b0;
      end
    end
  end

  task automatic gen(input int k, input int npk, input int fixed_len);
    int    len;
    beat_t b;
    for (int p = 0; p < npk; p++) begin
      len = (fixed_len != 0) ? fixed_len : int'($urandom_range(1, 4));
      for (int j = 0; j < len; j++) begin
        b = {(j == len - 1), DW'($urandom_range(M - 1)), W'($urandom)};
        src_q[k].push_back(b);
        exp_q[k].push_back(b);
      end
    end
  endtask

  task automatic run_phase(input int gap_pct, input int rdy_pct, input int budget);
    logic [S-1:0] hs;
    beat_t        b;
    int           cyc;
    int           left;
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      hs = s_valid_i & s_ready_o;
      @(posedge clk);
      #1;
      left = 0;
      for (int k = 0; k < S; k++) begin
        if (hs[k]) begin
          void'(src_q[k].pop_front());
          s_valid_i[k] = 1'b0;
        end
        if (!s_valid_i[k] && src_q[k].size() != 0 && int'($urandom_range(99)) >= gap_pct) begin
          b = src_q[k][0];
          s_data_i[k*W +: W]   = b[W-1:0];
          s_dest_i[k*DW +: DW] = b[W+DW-1:W];
          s_last_i[k]          = b[W+DW];
          s_valid_i[k]         = 1'b1;
        end
        left += src_q[k].size();
      end
      m_ready_i = (int'($urandom_range(99)) < rdy_pct);
      cyc++;
      if (left == 0 && s_valid_i == 0) break;
    end
    chk("phase_within_budget", cyc < budget, 1);
    left = 0;
    for (int k = 0; k < S; k++) left += exp_q[k].size();
    chk("scoreboard_drained", left, 0);
    m_ready_i = 1'b0;
    s_last_i  = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    s_data_i  = '0;
    s_dest_i  = '0;
    s_valid_i = '0;
    s_last_i  = '0;
    m_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single-beat packet from source 2.
    @(posedge clk); #1;
    s_valid_i = 5'b00100; s_last_i = 5'b00100;
    s_data_i[2*W +: W] = 8'hA5; s_dest_i[2*DW +: DW] = 2'd1; m_ready_i = 1'b1;
    @(negedge clk);
    chk("t1_arb_cycle_no_valid", m_valid_o, 0);
    @(posedge clk); @(negedge clk);
    chk("t1_id", m_id_o, 2);
    chk("t1_valid", m_valid_o, 1);
    chk("t1_ready", s_ready_o, 5'b00100);
    chk("t1_data", m_data_o, 8'hA5);
    @(posedge clk); #1 s_valid_i = '0;
    @(negedge clk);
    chk("t1_idle_valid", m_valid_o, 0);
    chk("t1_idle_busy", busy_o, 0);

    // Pointer now 3: sources 4 and 0... here 4 and 1 request; 4 wins, then 1 with no bubble.
    @(posedge clk); #1;
    s_valid_i = 5'b10010; s_last_i = 5'b10010;
    s_data_i[4*W +: W] = 8'h44; s_data_i[1*W +: W] = 8'h11;
    @(posedge clk); @(negedge clk);
    chk("t2_first_id", m_id_o, 4);
    @(posedge clk); #1 s_valid_i[4] = 1'b0;
    @(negedge clk);
    chk("t2_second_id", m_id_o, 1);
    chk("t2_second_valid", m_valid_o, 1);
    chk("t2_second_data", m_data_o, 8'h11);
    @(posedge clk); #1 s_valid_i = '0; s_last_i = '0;

    // Async reset mid-packet with pointer at 2; afterwards arbitration restarts at 0.
    @(posedge clk); #1;
    s_valid_i = 5'b00010; s_last_i = '0;
    @(posedge clk); #3;
    chk("t3_locked_before_reset", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("t3_async_ready", s_ready_o, 0);
    chk("t3_async_valid", m_valid_o, 0);
    chk("t3_async_busy", busy_o, 0);
    s_valid_i = 5'b10010; s_last_i = 5'b10010;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t3_restart_id", m_id_o, 1);
    @(posedge clk); #1 s_valid_i[1] = 1'b0;
    @(negedge clk);
    chk("t3_next_id", m_id_o, 4);
    @(posedge clk); #1 s_valid_i = '0; s_last_i = '0; m_ready_i = 1'b0;

    // Continuous 3-beat packets from every source: strict rotation, no idle cycles.
    sb_en = 1'b1;
    for (int k = 0; k < S; k++) gen(k, 4, 3);
    run_phase(0, 100, 2000);

    // Randomized gaps, lengths and back-pressure.
    for (int k = 0; k < S; k++) gen(k, 12, 0);
    run_phase(30, 70, 20000);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Registered, packet-locked round-robin arbiter and N:1 stream multiplexer for the crossbar's master-side ports.
- Selects one of S_DATA_COUNT valid/ready sources, holds the grant until the granted source's last beat completes a handshake, then rotates priority to the next source.
- Zero-bubble hand-over when another source is already waiting.
- Forwards data, last, source id and destination to a single master port with no added data latency.

Parameters:
- T_DATA_WIDTH, 8: data width per beat.
- S_DATA_COUNT, 5: number of sources; must be ≥ 2.
- M_DATA_COUNT, 3: number of crossbar masters; used only to size dest.
- T_ID___WIDTH, $clog2(S_DATA_COUNT): width of the source id.
- T_DEST_WIDTH, $clog2(M_DATA_COUNT): width of dest.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_data_i  in  S_DATA_COUNT*T_DATA_WIDTH  source data; source k occupies slice [k*T_DATA_WIDTH +: T_DATA_WIDTH].
- s_dest_i  in  S_DATA_COUNT*T_DEST_WIDTH  source destination, packed the same way.
- s_valid_i  in  S_DATA_COUNT  source valid.
- s_last_i  in  S_DATA_COUNT  source last beat of packet.
- s_ready_o  out  S_DATA_COUNT  source ready.
- m_data_o  out  T_DATA_WIDTH  data from the granted source.
- m_dest_o  out  T_DEST_WIDTH  dest from the granted source.
- m_id_o  out  T_ID___WIDTH  index of the granted source.
- m_valid_o  out  1  master valid.
- m_last_o  out  1  master last.
- m_ready_i  in  1  master ready.
- busy_o  out  1  high while a packet is locked.

Behaviour:
- Registers:
  - state: IDLE/LOCKED.
  - grant_q: id of the locked source.
  - ptr_q: highest-priority index for the next arbitration.
- Reset (rst_n low, asynchronous): state=IDLE, grant_q=0, ptr_q=0. Outputs while in reset: s_ready_o=0, m_valid_o=0, m_last_o=0, busy_o=0, m_id_o=0, m_data_o=0, m_dest_o=0.
- Reset release: first arbitration occurs on the first rising edge with rst_n high.
- Arbitration function: scan from ptr_q upward, wrapping S_DATA_COUNT-1 to 0; the first requesting index wins.
  - Implemented with a doubled request vector or explicit compare-and-wrap. No % operator.
  - All index arithmetic is sized to T_ID___WIDTH.
- IDLE:
  - s_ready_o=0, m_valid_o=0.
  - If any s_valid_i is set: grant_q<=winner, state<=LOCKED.
  - This costs one arbitration cycle, so the first beat appears on the cycle after the request.
- LOCKED:
  - m_valid_o=s_valid_i[grant_q].
  - m_last_o=s_last_i[grant_q] & s_valid_i[grant_q].
  - m_data_o, m_dest_o are the grant_q slices. m_id_o=grant_q.
  - s_ready_o[grant_q]=m_ready_i; all other s_ready_o bits=0. Combinational pass-through, zero latency.
  - busy_o=1.
- Handshake: a beat transfers when m_valid_o & m_ready_i.
  - Source valid gaps inside a packet do not release the grant.
- Last handshake (handshake & m_last_o):
  - ptr_q <= grant_q+1, wrapping to 0 after S_DATA_COUNT-1.
  - Re-arbitrate in the same cycle from that new pointer over s_valid_i with bit grant_q masked off.
  - If there is a winner: grant_q<=winner, stay LOCKED, no bubble. Otherwise state<=IDLE.
  - The just-finished source may win again only from IDLE, or when it is the only requester at a later arbitration.
- Fairness: with all sources continuously requesting, grants follow strict order k, k+1, …, wrapping. No source waits more than S_DATA_COUNT-1 packets.
- m_ready_i low: grant, pointer and outputs hold; the beat stays presented unchanged as long as the source holds it.
- s_valid_i asserted by non-granted sources during LOCKED: ignored; their s_ready_o stays 0.
- Reset mid-packet: the grant is dropped immediately and the partial packet is lost. The source is responsible for restarting it.
- No combinational path from s_valid_i to any register except via arbitration. No loops; outputs depend only on registers and current inputs.

Test Plan:
- Reset, then s_valid_i=5'b00100, single-beat packet with last=1, m_ready_i=1 → cycle 1: grant_q=2, m_id_o=2, m_valid_o=1, s_ready_o=5'b00100. After the handshake: ptr_q=3, state=IDLE, m_valid_o=0.
- All five sources continuously valid, 3-beat packets, m_ready_i=1 → m_id_o sequence 0,0,0,1,1,1,2,2,2,3,3,3,4,4,4,0… with no idle cycles between packets.
- Source 1 locked, 4-beat packet; source 3 raises valid mid-packet; m_ready_i toggles 1,0,1,0 → source 3 never sees s_ready; exactly 4 beats of source 1 pass, with data unchanged during stalls. Then m_id_o=3 on the next cycle after last.
- ptr_q=4, requests 5'b10001 → source 4 wins, then source 0 (wrap-around check).
- Source 2 holds valid with a gap (valid=0 for 2 cycles mid-packet) while source 0 requests → grant stays 2, m_valid_o=0 during the gap, no switch before last.
- Assert rst_n=0 asynchronously mid-packet, with no clock edge → s_ready_o and m_valid_o drop immediately to 0. After release, arbitration restarts from ptr_q=0.
